// File: rtl/ecc_point_mult.sv
// ecc_point_mult: sequential scalar multiplier Q = k*P on y^2 = x^3 + a*x + b over GF(p).
// Left-to-right double-and-add with shift-and-add modular multiply and
// binary extended-Euclid inversion.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-low reset
//   i_start           first (most-significant) nibble of a new operand set
//   a, prime, k,
//   Px, Py            4-bit nibble-serial operand inputs, MSN first
//   kPx, kPy          affine result; point at infinity reported as (0,0)
//   raw1              status: [31] done, [30] result is O, [29:24] bit index,
//                     [3:0] FSM state code
module ecc_point_mult #(
  parameter int unsigned SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [3:0]      a,
  input  logic [3:0]      prime,
  input  logic [3:0]      k,
  input  logic [3:0]      Px,
  input  logic [3:0]      Py,
  output logic [SIZE-1:0] kPx,
  output logic [SIZE-1:0] kPy,
  output logic [31:0]     raw1
);

  localparam int unsigned NIB = SIZE / 4;
  localparam int unsigned CW  = (NIB > 2) ? $clog2(NIB) : 1;
  localparam int unsigned BW  = $clog2(SIZE);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_COMPUTE = 4'd2,   // bit entry; also performs the doubling dispatch
    ST_DONE    = 4'd3,
    ST_DNUM    = 4'd4,
    ST_ADD     = 4'd5,
    ST_INV     = 4'd6,
    ST_LAM     = 4'd7,
    ST_X3      = 4'd8,
    ST_Y3      = 4'd9,
    ST_POST    = 4'd10,
    ST_MUL     = 4'd11,
    ST_FIN     = 4'd12
  } state_t;

  // (x + y) mod m for x, y < m
  function automatic logic [SIZE-1:0] mod_add(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                              input logic [SIZE-1:0] m);
    logic [SIZE:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[SIZE-1:0];
  endfunction

  // (x - y) mod m for x, y < m
  function automatic logic [SIZE-1:0] mod_sub(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                              input logic [SIZE-1:0] m);
    logic [SIZE:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[SIZE]) d = d + {1'b0, m};
    return d[SIZE-1:0];
  endfunction

  // x/2 mod m for odd m
  function automatic logic [SIZE-1:0] mod_half(input logic [SIZE-1:0] x, input logic [SIZE-1:0] m);
    logic [SIZE:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[SIZE:1];
  endfunction

  state_t state, state_nx, mul_ret, mul_ret_nx;

  logic [SIZE-1:0] a_r, p_r, k_r, px_r, py_r;
  logic [SIZE-1:0] a_nx, p_nx, k_nx, px_nx, py_nx;
  logic [CW-1:0]   nib_cnt, nib_cnt_nx;
  logic [SIZE-1:0] qx, qy, qx_nx, qy_nx;
  logic            q_inf, q_inf_nx;
  logic [BW-1:0]   bit_idx, bit_idx_nx;
  logic            phase_add, phase_add_nx;
  logic [SIZE-1:0] num_r, num_nx, xo_r, xo_nx, lam_r, lam_nx, t_r, t_nx;
  logic [SIZE-1:0] u_r, u_nx, v_r, v_nx, ix1_r, ix1_nx, ix2_r, ix2_nx;
  logic [SIZE-1:0] mul_a, mul_a_nx, mul_b, mul_b_nx, mul_acc, mul_acc_nx;
  logic [BW-1:0]   mul_cnt, mul_cnt_nx;
  logic [SIZE-1:0] kpx_nx, kpy_nx;
  logic            res_inf, res_inf_nx;
  logic [31:0]     raw1_nx;

  // Shared decisions used by both the next-state and datapath logic
  state_t          post_c;
  logic            dbl_trivial_c, add_dbl_c, inv_done_c;
  logic [SIZE-1:0] inv_c, x3_c, mul_step_c, addend_c;

  assign post_c        = (!phase_add && k_r[bit_idx]) ? ST_ADD
                       : ((bit_idx == '0) ? ST_FIN : ST_COMPUTE);
  assign dbl_trivial_c = q_inf || (qy == '0);
  assign add_dbl_c     = !q_inf && (qx == px_r) && (qy == py_r);
  // Zero checks only guard against operands that violate the gcd precondition
  assign inv_done_c    = (u_r == SIZE'(1)) || (v_r == SIZE'(1)) || (u_r == '0) || (v_r == '0);
  assign inv_c         = (u_r == SIZE'(1)) ? ix1_r : ix2_r;
  assign x3_c          = mod_sub(mod_sub(mul_acc, qx, p_r), xo_r, p_r);
  assign addend_c      = mul_b[mul_cnt] ? mul_a : '0;
  assign mul_step_c    = mod_add(mod_add(mul_acc, mul_acc, p_r), addend_c, p_r);

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (i_start) state_nx = ST_LOAD;
      ST_LOAD:    if (nib_cnt == CW'(NIB - 2)) state_nx = ST_COMPUTE;
      ST_COMPUTE: state_nx = dbl_trivial_c ? post_c : ST_MUL;
      ST_DNUM:    state_nx = ST_INV;
      ST_ADD: begin
        if (q_inf)           state_nx = post_c;
        else if (qx == px_r) state_nx = (qy == py_r) ? ST_COMPUTE : post_c;
        else                 state_nx = ST_INV;
      end
      ST_INV:     if (inv_done_c) state_nx = ST_MUL;
      ST_LAM:     state_nx = ST_MUL;
      ST_X3:      state_nx = ST_MUL;
      ST_Y3:      state_nx = ST_POST;
      ST_POST:    state_nx = post_c;
      ST_MUL:     if (mul_cnt == '0) state_nx = mul_ret;
      ST_FIN:     state_nx = ST_DONE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_nx = a_r;  p_nx = p_r;  k_nx = k_r;  px_nx = px_r;  py_nx = py_r;
    nib_cnt_nx   = nib_cnt;
    qx_nx        = qx;
    qy_nx        = qy;
    q_inf_nx     = q_inf;
    bit_idx_nx   = bit_idx;
    phase_add_nx = phase_add;
    num_nx = num_r;  xo_nx = xo_r;  lam_nx = lam_r;  t_nx = t_r;
    u_nx = u_r;  v_nx = v_r;  ix1_nx = ix1_r;  ix2_nx = ix2_r;
    mul_a_nx   = mul_a;
    mul_b_nx   = mul_b;
    mul_acc_nx = mul_acc;
    mul_cnt_nx = mul_cnt;
    mul_ret_nx = mul_ret;
    kpx_nx     = kPx;
    kpy_nx     = kPy;
    res_inf_nx = res_inf;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          a_nx  = {a,     {(SIZE-4){1'b0}}};
          p_nx  = {prime, {(SIZE-4){1'b0}}};
          k_nx  = {k,     {(SIZE-4){1'b0}}};
          px_nx = {Px,    {(SIZE-4){1'b0}}};
          py_nx = {Py,    {(SIZE-4){1'b0}}};
          nib_cnt_nx = '0;
        end
      end
      ST_LOAD: begin
        a_nx  = {a_r[SIZE-5:0],  a};
        p_nx  = {p_r[SIZE-5:0],  prime};
        k_nx  = {k_r[SIZE-5:0],  k};
        px_nx = {px_r[SIZE-5:0], Px};
        py_nx = {py_r[SIZE-5:0], Py};
        nib_cnt_nx = nib_cnt + CW'(1);
        if (nib_cnt == CW'(NIB - 2)) begin
          qx_nx        = '0;
          qy_nx        = '0;
          q_inf_nx     = 1'b1;
          bit_idx_nx   = BW'(SIZE - 1);
          phase_add_nx = 1'b0;
        end
      end
      ST_COMPUTE: begin
        if (dbl_trivial_c) begin
          q_inf_nx = 1'b1;
        end else begin
          mul_a_nx = qx;  mul_b_nx = qx;  mul_acc_nx = '0;
          mul_cnt_nx = BW'(SIZE - 1);  mul_ret_nx = ST_DNUM;
        end
      end
      ST_DNUM: begin
        // numerator 3x^2 + a, denominator 2y
        num_nx = mod_add(mod_add(mod_add(mul_acc, mul_acc, p_r), mul_acc, p_r), a_r, p_r);
        xo_nx  = qx;
        u_nx   = mod_add(qy, qy, p_r);
        v_nx   = p_r;
        ix1_nx = SIZE'(1);
        ix2_nx = '0;
      end
      ST_ADD: begin
        if (q_inf) begin
          qx_nx    = px_r;
          qy_nx    = py_r;
          q_inf_nx = 1'b0;
        end else if (qx == px_r) begin
          if (qy != py_r) q_inf_nx = 1'b1;
        end else begin
          num_nx = mod_sub(py_r, qy, p_r);
          xo_nx  = px_r;
          u_nx   = mod_sub(px_r, qx, p_r);
          v_nx   = p_r;
          ix1_nx = SIZE'(1);
          ix2_nx = '0;
        end
      end
      ST_INV: begin
        // Invariants: ix1*den == u, ix2*den == v (mod p)
        if (inv_done_c) begin
          mul_a_nx = num_r;  mul_b_nx = inv_c;  mul_acc_nx = '0;
          mul_cnt_nx = BW'(SIZE - 1);  mul_ret_nx = ST_LAM;
        end else if (!u_r[0]) begin
          u_nx   = u_r >> 1;
          ix1_nx = mod_half(ix1_r, p_r);
        end else if (!v_r[0]) begin
          v_nx   = v_r >> 1;
          ix2_nx = mod_half(ix2_r, p_r);
        end else if (u_r >= v_r) begin
          u_nx   = u_r - v_r;
          ix1_nx = mod_sub(ix1_r, ix2_r, p_r);
        end else begin
          v_nx   = v_r - u_r;
          ix2_nx = mod_sub(ix2_r, ix1_r, p_r);
        end
      end
      ST_LAM: begin
        lam_nx   = mul_acc;
        mul_a_nx = mul_acc;  mul_b_nx = mul_acc;  mul_acc_nx = '0;
        mul_cnt_nx = BW'(SIZE - 1);  mul_ret_nx = ST_X3;
      end
      ST_X3: begin
        t_nx     = x3_c;
        mul_a_nx = lam_r;  mul_b_nx = mod_sub(qx, x3_c, p_r);  mul_acc_nx = '0;
        mul_cnt_nx = BW'(SIZE - 1);  mul_ret_nx = ST_Y3;
      end
      ST_Y3: begin
        qx_nx    = t_r;
        qy_nx    = mod_sub(mul_acc, qy, p_r);
        q_inf_nx = 1'b0;
      end
      ST_MUL: begin
        mul_acc_nx = mul_step_c;
        mul_cnt_nx = mul_cnt - BW'(1);
      end
      ST_FIN: begin
        kpx_nx     = q_inf ? '0 : qx;
        kpy_nx     = q_inf ? '0 : qy;
        res_inf_nx = q_inf;
      end
      default: ;
    endcase

    // Bit bookkeeping: entering ADD starts the add phase; moving on to the
    // next bit happens on any return to COMPUTE except an add that degenerates
    // into a doubling of Q.
    if (state_nx == ST_ADD && state != ST_ADD) phase_add_nx = 1'b1;
    if (state_nx == ST_COMPUTE &&
        (state == ST_COMPUTE || state == ST_POST || (state == ST_ADD && !add_dbl_c))) begin
      bit_idx_nx   = bit_idx - BW'(1);
      phase_add_nx = 1'b0;
    end

    raw1_nx = {(state_nx == ST_DONE), res_inf_nx, 6'(bit_idx_nx), 20'd0, state_nx};
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_r <= '0;  p_r <= '0;  k_r <= '0;  px_r <= '0;  py_r <= '0;
      nib_cnt   <= '0;
      qx        <= '0;
      qy        <= '0;
      q_inf     <= 1'b1;
      bit_idx   <= '0;
      phase_add <= 1'b0;
      num_r <= '0;  xo_r <= '0;  lam_r <= '0;  t_r <= '0;
      u_r <= '0;  v_r <= '0;  ix1_r <= '0;  ix2_r <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_cnt <= '0;
      mul_ret <= ST_IDLE;
      kPx     <= '0;
      kPy     <= '0;
      res_inf <= 1'b0;
      raw1    <= '0;
    end else begin
      a_r <= a_nx;  p_r <= p_nx;  k_r <= k_nx;  px_r <= px_nx;  py_r <= py_nx;
      nib_cnt   <= nib_cnt_nx;
      qx        <= qx_nx;
      qy        <= qy_nx;
      q_inf     <= q_inf_nx;
      bit_idx   <= bit_idx_nx;
      phase_add <= phase_add_nx;
      num_r <= num_nx;  xo_r <= xo_nx;  lam_r <= lam_nx;  t_r <= t_nx;
      u_r <= u_nx;  v_r <= v_nx;  ix1_r <= ix1_nx;  ix2_r <= ix2_nx;
      mul_a   <= mul_a_nx;
      mul_b   <= mul_b_nx;
      mul_acc <= mul_acc_nx;
      mul_cnt <= mul_cnt_nx;
      mul_ret <= mul_ret_nx;
      kPx     <= kpx_nx;
      kPy     <= kpy_nx;
      res_inf <= res_inf_nx;
      raw1    <= raw1_nx;
    end
  end

endmodule

// File: tb/tb_ecc_point_mult.sv
// Directed testbench for ecc_point_mult on y^2 = x^3 + 2x + 2 over GF(17),
// base point P = (5,1) of order 19.
module tb_ecc_point_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  a_n, p_n, k_n, px_n, py_n;
  logic [31:0] kpx, kpy, raw1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ecc_point_mult #(.SIZE(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_start (start),
    .a       (a_n),
    .prime   (p_n),
    .k       (k_n),
    .Px      (px_n),
    .Py      (py_n),
    .kPx     (kpx),
    .kPy     (kpy),
    .raw1    (raw1)
  );

  // Shift in p=17, a=2, P=(5,1) and scalar kv, MSN first, over 8 cycles
  task automatic load_ops(input logic [31:0] kv);
    logic [31:0] av, pv, xv, yv;
    av = 32'd2;  pv = 32'd17;  xv = 32'd5;  yv = 32'd1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      start = (n == 0);
      a_n   = av[31-4*n -: 4];
      p_n   = pv[31-4*n -: 4];
      k_n   = kv[31-4*n -: 4];
      px_n  = xv[31-4*n -: 4];
      py_n  = yv[31-4*n -: 4];
    end
    @(negedge clk);
    start = 1'b0;
    a_n = '0;  p_n = '0;  k_n = '0;  px_n = '0;  py_n = '0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (raw1[31] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a_n = '0;  p_n = '0;  k_n = '0;  px_n = '0;  py_n = '0;
    #12;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (kpx !== 32'd0) $display("FAIL reset_kPx: got %0h expected 0", kpx); else n_pass++;
    n_checks++;
    if (kpy !== 32'd0) $display("FAIL reset_kPy: got %0h expected 0", kpy); else n_pass++;
    n_checks++;
    if (raw1 !== 32'd0) $display("FAIL reset_raw1: got %h expected 00000000", raw1); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (raw1[3:0] !== 4'd0) $display("FAIL idle_state: got %0d expected 0", raw1[3:0]); else n_pass++;
    n_checks++;
    if (raw1 !== 32'd0) $display("FAIL idle_raw1: got %h expected 00000000", raw1); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    load_ops(32'd2);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL basic_done: got %0d expected 1", ok); else n_pass++;
    n_checks++;
    if (kpx !== 32'd6) $display("FAIL basic_kPx: got %0d expected 6", kpx); else n_pass++;
    n_checks++;
    if (kpy !== 32'd3) $display("FAIL basic_kPy: got %0d expected 3", kpy); else n_pass++;
    n_checks++;
    if (raw1 !== 32'h8000_0003) $display("FAIL basic_raw1: got %h expected 80000003", raw1); else n_pass++;
  endtask

  task automatic test_infinity();
    logic [31:0] kv [3];
    logic [31:0] ex [3];
    logic [31:0] ey [3];
    logic [31:0] er [3];
    bit ok;
    kv = '{32'd19, 32'd20, 32'd0};
    ex = '{32'd0, 32'd5, 32'd0};
    ey = '{32'd0, 32'd1, 32'd0};
    er = '{32'hC000_0003, 32'h8000_0003, 32'hC000_0003};
    for (int i = 0; i < 3; i++) begin
      load_ops(kv[i]);
      wait_done(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL inf_done k=%0d: got %0d expected 1", kv[i], ok); else n_pass++;
      n_checks++;
      if (kpx !== ex[i]) $display("FAIL inf_kPx k=%0d: got %0d expected %0d", kv[i], kpx, ex[i]);
      else n_pass++;
      n_checks++;
      if (kpy !== ey[i]) $display("FAIL inf_kPy k=%0d: got %0d expected %0d", kv[i], kpy, ey[i]);
      else n_pass++;
      n_checks++;
      if (raw1 !== er[i]) $display("FAIL inf_raw1 k=%0d: got %h expected %h", kv[i], raw1, er[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sequence();
    logic [31:0] kv [4];
    logic [31:0] ex [4];
    logic [31:0] ey [4];
    bit ok;
    kv = '{32'd3, 32'd5, 32'd7, 32'd10};
    ex = '{32'd10, 32'd9, 32'd0, 32'd7};
    ey = '{32'd6, 32'd16, 32'd6, 32'd11};
    for (int i = 0; i < 4; i++) begin
      load_ops(kv[i]);
      wait_done(ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL seq_done k=%0d: got %0d expected 1", kv[i], ok); else n_pass++;
      n_checks++;
      if (kpx !== ex[i]) $display("FAIL seq_kPx k=%0d: got %0d expected %0d", kv[i], kpx, ex[i]);
      else n_pass++;
      n_checks++;
      if (kpy !== ey[i]) $display("FAIL seq_kPy k=%0d: got %0d expected %0d", kv[i], kpy, ey[i]);
      else n_pass++;
      n_checks++;
      if (raw1 !== 32'h8000_0003) $display("FAIL seq_raw1 k=%0d: got %h expected 80000003", kv[i], raw1);
      else n_pass++;
    end
  endtask

  // Previous result is (7,11) from k=10; a stray i_start mid-compute is ignored
  task automatic test_back_to_back();
    bit ok;
    bit held;
    bit state_ok;
    held     = 1'b1;
    state_ok = 1'b1;
    load_ops(32'd9);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 5) begin
        start = 1'b1;  k_n = 4'hF;  a_n = 4'hF;
      end else if (c == 6) begin
        start = 1'b0;  k_n = '0;    a_n = '0;
      end
      if (kpx !== 32'd7 || kpy !== 32'd11 || raw1[31] !== 1'b0) held = 1'b0;
      if (raw1[3:0] === 4'd0 || raw1[3:0] === 4'd1 || raw1[3:0] === 4'd3) state_ok = 1'b0;
    end
    n_checks++;
    if (held !== 1'b1) $display("FAIL b2b_hold: got held=%0d expected held=1 (kPx=%0d kPy=%0d)", held, kpx, kpy);
    else n_pass++;
    n_checks++;
    if (state_ok !== 1'b1) $display("FAIL b2b_state: got in_compute=%0d expected 1", state_ok); else n_pass++;
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL b2b_done: got %0d expected 1", ok); else n_pass++;
    n_checks++;
    if (kpx !== 32'd7) $display("FAIL b2b_kPx: got %0d expected 7", kpx); else n_pass++;
    n_checks++;
    if (kpy !== 32'd6) $display("FAIL b2b_kPy: got %0d expected 6", kpy); else n_pass++;
    n_checks++;
    if (raw1 !== 32'h8000_0003) $display("FAIL b2b_raw1: got %h expected 80000003", raw1); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    load_ops(32'd4);
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (kpx !== 32'd0) $display("FAIL abort_kPx: got %0d expected 0", kpx); else n_pass++;
    n_checks++;
    if (kpy !== 32'd0) $display("FAIL abort_kPy: got %0d expected 0", kpy); else n_pass++;
    n_checks++;
    if (raw1 !== 32'd0) $display("FAIL abort_raw1: got %h expected 00000000", raw1); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    load_ops(32'd4);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL abort_done: got %0d expected 1", ok); else n_pass++;
    n_checks++;
    if (kpx !== 32'd3) $display("FAIL abort_kPx_k4: got %0d expected 3", kpx); else n_pass++;
    n_checks++;
    if (kpy !== 32'd1) $display("FAIL abort_kPy_k4: got %0d expected 1", kpy); else n_pass++;
    n_checks++;
    if (raw1 !== 32'h8000_0003) $display("FAIL abort_raw1_k4: got %h expected 80000003", raw1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_infinity();
    test_sequence();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
